// File: rtl/vga_timing_pkg.sv
// 640x480 VGA timing constants, derived window/tile sizes and lock FSM states
// shared by the sync decoder.
package vga_timing_pkg;
  localparam int H_ACTIVE = 640;
  localparam int H_BP     = 48;
  localparam int H_SYNC   = 96;
  localparam int H_TOTAL  = 800;
  localparam int V_ACTIVE = 480;
  localparam int V_BP     = 33;
  localparam int V_SYNC   = 2;
  localparam int V_TOTAL  = 525;

  localparam int H_START = H_SYNC + H_BP;
  localparam int V_START = V_SYNC + V_BP;
  localparam int TILE_W  = H_ACTIVE / 4;
  localparam int TILE_H  = V_ACTIVE / 2;

  localparam logic [9:0] IDX_MAX = 10'h3FF;

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} sync_state_e;

  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == IDX_MAX) ? v : v + 10'd1;
  endfunction
endpackage

// File: rtl/sync_edge_det.sv
// Registers one active-low sync input and flags its falling edge on the
// same sample the low level first appears.
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic sync_n,
  output logic fall
);
  logic prev;

  always_ff @(posedge clk) begin
    if (rst) prev <= 1'b1;
    else     prev <= sync_n;
  end

  assign fall = prev & ~sync_n;
endmodule

// File: rtl/vga_sync_decoder.sv
// VGA receive-side decoder: pixel coordinates, line/frame timing check, lock FSM.
// Define VGA_TILE_CAPTURE_EN to latch one sample colour per 4x2 screen tile.
module vga_sync_decoder #(
  parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int H_BP     = vga_timing_pkg::H_BP,
  parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int H_TOTAL  = vga_timing_pkg::H_TOTAL,
  parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int V_BP     = vga_timing_pkg::V_BP,
  parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int V_TOTAL  = vga_timing_pkg::V_TOTAL
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        VGA_Hsync_n,
  input  logic        VGA_Vsync_n,
  input  logic        VGA_R,
  input  logic        VGA_G,
  input  logic        VGA_B,
  output logic [9:0]  posX,
  output logic [8:0]  posY,
  output logic [2:0]  rgb_out,
  output logic        pixel_valid,
  output logic        locked,
  output logic        frame_done,
  output logic [7:0]  err_count,
  output logic [23:0] tile_colors
);
  import vga_timing_pkg::*;

  // Window edges come from the instance parameters so reduced timings stay consistent.
  localparam logic [9:0]  X_LO    = 10'(H_SYNC + H_BP);
  localparam logic [9:0]  X_HI    = 10'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [9:0]  Y_LO    = 10'(V_SYNC + V_BP);
  localparam logic [9:0]  Y_HI    = 10'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [9:0]  H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [10:0] V_LINES = 11'(V_TOTAL);

  logic [1:0]  sync_fall;
  logic        h_fall, v_fall;
  logic [9:0]  hcnt, vcnt, hidx, vidx, y_off;
  logic        h_seen, v_seen, meas_clean, active;
  logic        line_bad, frame_bad, wdog, viol, frame_ok;
  sync_state_e state_q, state_d;

  sync_edge_det u_edge [1:0] (
    .clk    (clk),
    .rst    (rst),
    .sync_n ({VGA_Vsync_n, VGA_Hsync_n}),
    .fall   (sync_fall)
  );

  assign h_fall = sync_fall[0];
  assign v_fall = sync_fall[1];

  always_comb begin
    hidx = h_fall ? 10'd0 : sat_inc(hcnt);
    vidx = vcnt;
    if (v_fall)      vidx = 10'd0;
    else if (h_fall) vidx = sat_inc(vcnt);
    active    = (hidx >= X_LO) && (hidx < X_HI) && (vidx >= Y_LO) && (vidx < Y_HI);
    y_off     = vidx - Y_LO;
    // hcnt/vcnt hold the previous sample, so the interval is count+1
    line_bad  = h_fall && h_seen && (hcnt != H_LAST);
    frame_bad = v_fall && v_seen && (({1'b0, vcnt} + {10'd0, h_fall}) != V_LINES);
    wdog      = (hidx == IDX_MAX);
    viol      = line_bad || frame_bad || wdog;
    frame_ok  = v_fall && v_seen && !viol;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt   <= '0;
      vcnt   <= '0;
      h_seen <= 1'b0;
      v_seen <= 1'b0;
    end else begin
      hcnt <= hidx;
      vcnt <= vidx;
      if (h_fall) h_seen <= 1'b1;
      if (v_fall) v_seen <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      posX        <= '0;
      posY        <= '0;
      rgb_out     <= '0;
      pixel_valid <= 1'b0;
    end else if (active) begin
      posX        <= hidx - X_LO;
      posY        <= y_off[8:0];
      rgb_out     <= {VGA_R, VGA_G, VGA_B};
      pixel_valid <= 1'b1;
    end else begin
      rgb_out     <= '0;
      pixel_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= SEARCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SEARCH:  if (v_fall) state_d = MEASURE;
      MEASURE: if (frame_ok && meas_clean) state_d = LOCKED;
      LOCKED:  if (viol) state_d = SEARCH;
      default: state_d = SEARCH;
    endcase
  end

  always_comb locked = (state_q == LOCKED);

  always_ff @(posedge clk) begin
    if (rst) begin
      err_count  <= '0;
      frame_done <= 1'b0;
      meas_clean <= 1'b0;
    end else begin
      frame_done <= locked && frame_ok;
      if (locked && viol && err_count != 8'hFF) err_count <= err_count + 8'd1;
      // a measurement frame only qualifies if no line in it misbehaved
      if (state_q != MEASURE || v_fall) meas_clean <= 1'b1;
      else if (viol)                    meas_clean <= 1'b0;
    end
  end

`ifdef VGA_TILE_CAPTURE_EN
  localparam int TW = H_ACTIVE / 4;
  localparam int TH = V_ACTIVE / 2;

  logic [7:0][2:0] tile_q;

  for (genvar k = 0; k < 8; k++) begin : g_tile
    localparam logic [9:0] CX = 10'(TW * (k % 4) + TW / 2);
    localparam logic [8:0] CY = 9'((k >= 4) ? (TH + TH / 2) : (TH / 2));
    logic [2:0] col;

    always_ff @(posedge clk) begin
      if (rst || state_d != LOCKED)                      col <= '0;
      else if (locked && pixel_valid && posX == CX && posY == CY) col <= rgb_out;
    end

    assign tile_q[k] = col;
  end

  assign tile_colors = tile_q;
`else
  assign tile_colors = '0;
`endif
endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder on a reduced 12x7 timing so full frames stay short.
module tb_vga_sync_decoder;
  localparam int HA = 8, HBP = 1, HS = 2, HT = 12;
  localparam int VA = 4, VBP = 1, VS = 1, VT = 7;
  localparam int X0 = HS + HBP, Y0 = VS + VBP;
`ifdef VGA_TILE_CAPTURE_EN
  localparam logic [23:0] TILE_EXP = 24'o76543210;
`else
  localparam logic [23:0] TILE_EXP = 24'o0;
`endif

  logic        clk = 1'b0, rst = 1'b1, hs_n = 1'b1, vs_n = 1'b1;
  logic [2:0]  col = 3'd0;
  logic [9:0]  posX;
  logic [8:0]  posY;
  logic [2:0]  rgb_out;
  logic        pixel_valid, locked, frame_done;
  logic [7:0]  err_count;
  logic [23:0] tile_colors;

  int checks = 0, errors = 0, fd_cnt = 0, lx = 0, ly = 0;

  vga_sync_decoder #(
    .H_ACTIVE(HA), .H_BP(HBP), .H_SYNC(HS), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_BP(VBP), .V_SYNC(VS), .V_TOTAL(VT)
  ) dut (
    .clk(clk), .rst(rst), .VGA_Hsync_n(hs_n), .VGA_Vsync_n(vs_n),
    .VGA_R(col[2]), .VGA_G(col[1]), .VGA_B(col[0]),
    .posX(posX), .posY(posY), .rgb_out(rgb_out), .pixel_valid(pixel_valid),
    .locked(locked), .frame_done(frame_done), .err_count(err_count),
    .tile_colors(tile_colors)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done) fd_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_posx"}, posX, 0);
    chk({tag, "_posy"}, posY, 0);
    chk({tag, "_rgb"}, rgb_out, 0);
    chk({tag, "_pv"}, pixel_valid, 0);
    chk({tag, "_lock"}, locked, 0);
    chk({tag, "_fd"}, frame_done, 0);
    chk({tag, "_err"}, err_count, 0);
    chk({tag, "_tiles"}, tile_colors, 0);
  endtask

  // One frame of stream; -1 disables the optional short line, checks and reset point.
  task automatic drive_frame(input int short_line, input int exp_lock, input int exp_fd,
                             input bit pix, input int rst_at);
    bit stop;
    stop = 1'b0;
    for (int l = 0; l < VT && !stop; l++) begin
      for (int h = 0; h < ((l == short_line) ? HT - 1 : HT) && !stop; h++) begin
        bit act;
        int x, y;
        act  = (h >= X0) && (h < X0 + HA) && (l >= Y0) && (l < Y0 + VA);
        x    = h - X0;
        y    = l - Y0;
        hs_n = (h >= HS);
        vs_n = (l >= VS);
        if (!act)                col = 3'd0;
        else if (x == 0 && y == 0) col = 3'b101;
        else                     col = 3'((y >= VA / 2 ? 4 : 0) + x / (HA / 4));
        rst  = (l == rst_at) && (h == 5);
        @(posedge clk); #1;
        if (rst) begin
          chk_zero("midrst");
          rst  = 1'b0;
          stop = 1'b1;
        end else begin
          if (act) begin lx = x; ly = y; end
          if (l == 0 && h == 0) begin
            if (exp_lock >= 0) chk("lock_sof", locked, exp_lock);
            if (exp_fd >= 0)   chk("fdone_sof", frame_done, exp_fd);
          end
          if (short_line >= 0 && l == short_line + 1 && h == 0) chk("lock_drop", locked, 0);
          if (pix) begin
            chk("pix_vld", pixel_valid, act);
            chk("pos_x", posX, lx);
            chk("pos_y", posY, ly);
            chk("rgb", rgb_out, act ? col : 3'd0);
          end
        end
      end
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");

    drive_frame(-1, 0, 0, 0, -1);
    drive_frame(-1, 1, 0, 1, -1);
    drive_frame(-1, 1, 1, 1, -1);
    drive_frame(-1, 1, 1, 0, -1);
    chk("err_clean", err_count, 0);
    chk("fd_count", fd_cnt, 2);

    drive_frame(2, 1, 1, 1, -1);
    chk("err_short", err_count, 1);
    drive_frame(-1, 0, 0, 0, -1);
    drive_frame(-1, 1, 0, 0, -1);
    drive_frame(-1, 1, 1, 0, -1);

    hs_n = 1'b1; vs_n = 1'b1; col = 3'd0;
    for (int j = 1; j <= 1100; j++) begin
      @(posedge clk); #1;
      if (j == 1011) chk("wdog_pre", locked, 1);
      if (j == 1012) begin
        chk("wdog_err", err_count, 2);
        chk("wdog_lock", locked, 0);
        chk("wdog_tiles", tile_colors, 0);
      end
    end
    chk("wdog_once", err_count, 2);

    drive_frame(-1, 0, 0, 0, -1);
    chk("tiles_pre", tile_colors, 0);
    drive_frame(-1, 1, 0, 0, -1);
    chk("tiles", tile_colors, TILE_EXP);
    drive_frame(-1, 1, 1, 0, -1);

    for (int i = 0; i < 258; i++) begin
      drive_frame(0, 1, -1, 0, -1);
      chk("err_sat", err_count, (3 + i > 255) ? 255 : 3 + i);
      drive_frame(-1, 0, 0, 0, -1);
    end
    chk("err_final", err_count, 255);

    drive_frame(-1, 1, 0, 0, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
